regfile_wr_arbiter: RTL
=======================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter DATA_W, default 64, width of the write data.
REQ-002 Parameter ADDR_W, default 5, width of the register index.
REQ-003 Parameter ZERO_REG, default 31, index of the hard-wired zero register.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  when high, no request is granted this cycle.
REQ-007 req0_valid  input  1  requester 0 (ALU writeback) holds a write.
REQ-008 req0_reg  input  ADDR_W  destination register of requester 0.
REQ-009 req0_data  input  DATA_W  write data of requester 0.
REQ-010 req0_ready  output  1  requester 0 write accepted this cycle.
REQ-011 req1_valid, req1_reg, req1_data, req1_ready  same directions, widths and meanings as the req0 ports, for requester 1 (load writeback).
REQ-012 RegWrite  output  1  register-file write enable, which drives the write-address decoder enable.
REQ-013 WriteRegister  output  ADDR_W  register-file write index.
REQ-014 WriteData  output  DATA_W  register-file write data.
REQ-015 last_grant  output  1  ID of the most recently granted requester (round-robin state).

Function
REQ-016 Arbiter state: two states, LAST0 and LAST1. The state SHALL be exposed as last_grant (0 = LAST0, 1 = LAST1).
REQ-017 Grant is combinational from req0_valid, req1_valid, stall and the state. A requester is accepted in any cycle where its reqN_valid and reqN_ready are both high.
REQ-018 stall=1: req0_ready and req1_ready SHALL both be 0.
REQ-019 stall=0, exactly one valid: that requester's ready SHALL be 1.
REQ-020 stall=0, both valid: grant requester 1 in LAST0 and requester 0 in LAST1.
REQ-021 req0_ready and req1_ready SHALL never be 1 in the same cycle.
REQ-022 reqN_ready SHALL never be 1 while reqN_valid is 0.
REQ-023 On accepting requester N, the state SHALL become LASTN. With no accept, the state holds.
REQ-024 Latency: an accept in cycle t SHALL present the write in cycle t+1:
- WriteRegister and WriteData equal to the granted request's reg and data;
- RegWrite=1 for exactly that one cycle.
REQ-025 Accepted writes with reg == ZERO_REG: the ready handshake SHALL complete normally, RegWrite SHALL stay 0 in t+1, and WriteRegister/WriteData SHALL still update.
REQ-026 With no accept in cycle t, RegWrite SHALL be 0 in t+1, and WriteRegister/WriteData SHALL hold their previous values.
REQ-027 Back-to-back accepts SHALL produce RegWrite=1 in consecutive cycles with no bubble.
REQ-028 Both valid with the same non-zero reg: only the granted write is issued in t+1. The loser stays pending and is written in a later cycle, so it ends up as the last value written to that register.
REQ-029 Fairness: a requester holding valid with stall=0 SHALL be accepted within 2 cycles.
REQ-030 Requesters must hold reg and data stable while valid is high and not yet accepted. The arbiter SHALL not buffer unaccepted requests.

Reset
REQ-031 With reset_n=0, asynchronously and independent of clk, the block SHALL force:
- RegWrite=0, WriteRegister=0, WriteData=0;
- state LAST1, so requester 0 wins the first contention.
REQ-032 While reset_n=0, req0_ready and req1_ready SHALL be 0.
REQ-033 A request accepted in the cycle reset asserts SHALL be discarded: no RegWrite after reset releases.
REQ-034 The first accept is possible in the first rising edge at which reset_n is high.

Verification
REQ-035 Reset, then req0_valid=1, reg=5, data=0xAA, for one cycle -> req0_ready=1; next cycle RegWrite=1, WriteRegister=5, WriteData=0xAA; the cycle after, RegWrite=0.
REQ-036 Both valid for 4 cycles (req0 reg=1, req1 reg=2) -> grant order 0,1,0,1 with each request re-presented after acceptance; RegWrite high for 4 consecutive cycles; last_grant toggles each cycle.
REQ-037 Both valid, req0 reg=7 data=0x11, req1 reg=7 data=0x22, state LAST0 -> writes are reg 7 = 0x22, then reg 7 = 0x11 the next cycle.
REQ-038 req1_valid=1, reg=31, data=0xFF -> req1_ready=1; next cycle RegWrite=0 and WriteRegister=31.
REQ-039 stall=1 for 3 cycles with req0 valid -> req0_ready=0 and RegWrite=0 throughout; stall drops -> accepted that cycle, written in the next.
REQ-040 reset_n pulsed low mid-stream, asynchronous to clk -> RegWrite drops to 0 immediately; no write issues for the in-flight accept; last_grant=1.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter.
// Two writeback sources (0 = ALU, 1 = load) share the single register-file
// write port. Grants alternate round-robin under contention, and an accepted
// write reaches the register file one cycle later.
//
// Handshake: a requester raises reqN_valid with reqN_reg/reqN_data and holds
// them stable until it sees reqN_ready high in the same cycle. valid & ready
// in a cycle means the write is accepted at that rising edge. ready is never
// high without valid, and at most one ready is high per cycle. Unaccepted
// requests are not buffered here; the requester keeps presenting them.
module regfile_wr_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              last_grant
);

  // Index of the hard-wired zero register, sized to the write index.
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  // Round-robin state: which requester was granted most recently.
  typedef enum logic {
    LAST0 = 1'b0,
    LAST1 = 1'b1
  } state_t;

  state_t state;

  logic grant0;
  logic grant1;

  // Grant selection: stall or reset blocks everything, a lone requester
  // always wins, contention goes to the requester not granted last time.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n && !stall) begin
      if (req0_valid && req1_valid) begin
        if (state == LAST0) begin
          grant1 = 1'b1;
        end else begin
          grant0 = 1'b1;
        end
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign last_grant = logic'(state);

  // Arbiter state and registered write port. Reset leaves LAST1 so that
  // requester 0 wins the first contention. Writes to the zero register
  // still update index/data but never raise the write enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= LAST1;
      RegWrite      <= 1'b0;
      WriteRegister <= '0;
      WriteData     <= '0;
    end else begin
      RegWrite <= 1'b0;
      if (grant0) begin
        state         <= LAST0;
        RegWrite      <= (req0_reg != ZERO_IDX);
        WriteRegister <= req0_reg;
        WriteData     <= req0_data;
      end else if (grant1) begin
        state         <= LAST1;
        RegWrite      <= (req1_reg != ZERO_IDX);
        WriteRegister <= req1_reg;
        WriteData     <= req1_data;
      end
    end
  end

endmodule
